iter_shift_unit: RTL

Multi-cycle sequential shift/rotate unit for the RISC-V core. It is the registered, handshaked counterpart of the core's combinational shifter. It accepts one shift request on a valid/ready input port and shifts the operand at most STEP bit positions per clock. It returns the result on a valid/ready output port. Intended for area-reduced core variants and for Zbb rotate support.

---
 rtl/iter_shift_unit.sv | 114 +++++++++++
 1 files changed

// File: rtl/iter_shift_unit.sv
// Multi-cycle shift/rotate unit: accepts one request on a valid/ready port,
// shifts the latched operand at most STEP positions per clock, and returns
// the registered result on a valid/ready port.
//
// The shift-type input is named type_i because "type" is a reserved word.
//
// DONE takes one cycle to register the result, then holds it. That cycle
// is why out_valid appears 1 + ceil(shamt/STEP) cycles after acceptance.
module iter_shift_unit #(
    parameter int STEP = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a,
    input  logic [4:0]  shamt,
    input  logic [1:0]  type_i,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] r,
    output logic        busy
);

    localparam logic [4:0] STEP_K = 5'(STEP);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t      state_q;
    logic [31:0] work_q;
    logic [4:0]  rem_q;
    logic [1:0]  typ_q;
    logic [31:0] r_q;
    logic        ov_q;

    logic [4:0]  step_k;
    logic [31:0] work_d;
    logic [4:0]  rem_d;

    // Shift a word by k positions according to the latched operation type.
    function automatic logic [31:0] shift_step(input logic [31:0] w,
                                               input logic [4:0]  k,
                                               input logic [1:0]  t);
        logic [63:0] rot;
        logic [31:0] res;
        rot = {w, w} >> k;
        case (t)
            2'b00:   res = w << k;
            2'b01:   res = w >> k;
            2'b10:   res = $signed(w) >>> k;
            default: res = rot[31:0];
        endcase
        return res;
    endfunction

    // Per-cycle step size and next working value while in SHIFT.
    always_comb begin
        step_k = (rem_q < STEP_K) ? rem_q : STEP_K;
        work_d = shift_step(work_q, step_k, typ_q);
        rem_d  = rem_q - step_k;
    end

    // Control FSM with registered result and output valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            work_q  <= 32'd0;
            rem_q   <= 5'd0;
            typ_q   <= 2'd0;
            r_q     <= 32'd0;
            ov_q    <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        work_q  <= a;
                        rem_q   <= shamt;
                        typ_q   <= type_i;
                        state_q <= (shamt == 5'd0) ? S_DONE : S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    work_q <= work_d;
                    rem_q  <= rem_d;
                    if (rem_d == 5'd0) begin
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (!ov_q) begin
                        r_q  <= work_q;
                        ov_q <= 1'b1;
                    end else if (out_ready) begin
                        ov_q    <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign out_valid = ov_q;
    assign r         = r_q;

endmodule
